// File: rtl/mcp3008_pkg.sv
// Shared definitions for the MCP3008 responder and the ADC-polling master.
// Holds result/channel widths, command and frame lengths, the responder
// state encoding and the decoded command payload.
package mcp3008_pkg;

  localparam int unsigned N          = 10;  // result width
  localparam int unsigned CHANNELS   = 8;   // fixed by the 3 channel bits
  localparam int unsigned CHAN_W     = 3;
  localparam int unsigned CMD_BITS   = 4;   // SGL, D2, D1, D0
  localparam int unsigned FRAME_BITS = 24;  // standard 3-byte frame
  localparam int unsigned LSB_BITS   = N - 1;  // trailer repeats B1..B9
  localparam int unsigned CNT_W      = 4;   // wide enough for N-1

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    SAMPLE,
    NULL,
    MSB,
    LSB,
    ZERO
  } state_t;

  // Decoded command: SGL/DIFF select followed by D2..D0.
  typedef struct packed {
    logic              sgl;
    logic [CHAN_W-1:0] chan;
  } cmd_t;

endpackage

// File: rtl/mcp3008_result_sel.sv
// Conversion result selection for the MCP3008 responder.
// Single-ended: returns chan_data[chan].
// Pseudo-differential: IN+ is chan_data[chan], IN- the other member of the
// pair chan[2:1]; returns IN+ - IN-, clamped to 0 when IN- exceeds IN+.
// Ports:
//   chan_data  value presented per channel
//   sgl        1 = single-ended, 0 = pseudo-differential
//   chan       D2..D0 from the command
//   result     selected / subtracted N-bit value (combinational)
module mcp3008_result_sel
  import mcp3008_pkg::*;
(
  input  logic [CHANNELS-1:0][N-1:0] chan_data,
  input  logic                       sgl,
  input  logic [CHAN_W-1:0]          chan,
  output logic [N-1:0]               result
);

  logic [CHAN_W-1:0] neg_idx;
  logic [N-1:0]      in_pos;
  logic [N-1:0]      in_neg;

  // IN+ is always the addressed channel; IN- is its pair partner.
  always_comb begin
    neg_idx = {chan[CHAN_W-1:1], ~chan[0]};
    in_pos  = chan_data[chan];
    in_neg  = chan_data[neg_idx];
    result  = '0;
    if (sgl) begin
      result = in_pos;
    end else if (in_pos >= in_neg) begin
      result = in_pos - in_neg;
    end
  end

endmodule

// File: rtl/mcp3008_responder.sv
// SPI responder emulating an MCP3008 8-channel 10-bit ADC. Decodes the
// command on DIN (sampled on rising SCLK) and returns the value from
// chan_data on DOUT (updated on falling SCLK): null bit, B9..B0, then the
// B1..B9 trailer, then zeros while CS_n stays low.
// Ports:
//   SCLK         SPI clock from the master, the only clock
//   reset_n      asynchronous active-low reset
//   CS_n         chip select, active-low
//   DIN          command data from the master
//   chan_data    value presented per channel
//   DOUT         result data to the master
//   DOUT_oe      DOUT drive enable (= ~CS_n, combinational)
//   conv_done    one-SCLK pulse when a sample is latched
//   last_sgl     SGL/DIFF bit of the last accepted command
//   last_chan    D2..D0 of the last accepted command
//   last_result  value latched by the last conversion
module mcp3008_responder
  import mcp3008_pkg::*;
(
  input  logic                       SCLK,
  input  logic                       reset_n,
  input  logic                       CS_n,
  input  logic                       DIN,
  input  logic [CHANNELS-1:0][N-1:0] chan_data,
  output logic                       DOUT,
  output logic                       DOUT_oe,
  output logic                       conv_done,
  output logic                       last_sgl,
  output logic [CHAN_W-1:0]          last_chan,
  output logic [N-1:0]               last_result
);

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_d;
  cmd_t              cmd_reg;
  cmd_t              cmd_d;
  logic [N-1:0]      shift_reg;
  logic [N-1:0]      shift_d;
  logic              conv_done_d;
  logic              last_sgl_d;
  logic [CHAN_W-1:0] last_chan_d;
  logic [N-1:0]      last_result_d;
  logic [N-1:0]      sel_result;
  logic [CNT_W-1:0]  msb_idx;
  logic [CNT_W-1:0]  lsb_idx;
  logic              dout_d;

  // Output driver is released as soon as the master deselects us.
  assign DOUT_oe = ~CS_n;

  mcp3008_result_sel u_result_sel (
    .chan_data (chan_data),
    .sgl       (cmd_reg.sgl),
    .chan      (cmd_reg.chan),
    .result    (sel_result)
  );

  // State register.
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Rising-edge datapath registers.
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      cmd_reg     <= '0;
      shift_reg   <= '0;
      conv_done   <= 1'b0;
      last_sgl    <= 1'b0;
      last_chan   <= '0;
      last_result <= '0;
    end else begin
      bit_cnt     <= bit_cnt_d;
      cmd_reg     <= cmd_d;
      shift_reg   <= shift_d;
      conv_done   <= conv_done_d;
      last_sgl    <= last_sgl_d;
      last_chan   <= last_chan_d;
      last_result <= last_result_d;
    end
  end

  // Next-state and rising-edge datapath decode.
  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    cmd_d         = cmd_reg;
    shift_d       = shift_reg;
    conv_done_d   = 1'b0;
    last_sgl_d    = last_sgl;
    last_chan_d   = last_chan;
    last_result_d = last_result;

    if (CS_n) begin
      // Deselect aborts whatever is in flight.
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      unique case (state)
        // The selecting edge is already a start-bit candidate.
        IDLE, WAIT_START: begin
          state_d = WAIT_START;
          if (DIN) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end
        CMD: begin
          cmd_d = cmd_t'({cmd_reg.chan, DIN});
          if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
            state_d   = SAMPLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          shift_d       = sel_result;
          last_result_d = sel_result;
          last_sgl_d    = cmd_reg.sgl;
          last_chan_d   = cmd_reg.chan;
          conv_done_d   = 1'b1;
          state_d       = NULL;
        end
        NULL: begin
          state_d   = MSB;
          bit_cnt_d = '0;
        end
        MSB: begin
          if (bit_cnt == CNT_W'(N - 1)) begin
            state_d   = LSB;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + CNT_W'(1);
          end
        end
        LSB: begin
          if (bit_cnt == CNT_W'(LSB_BITS - 1)) begin
            state_d   = ZERO;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + CNT_W'(1);
          end
        end
        ZERO: begin
          state_d = ZERO;
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  // Bit presented on the next falling edge: B9..B0 in MSB, B1..B9 in LSB.
  always_comb begin
    msb_idx = CNT_W'(N - 1) - bit_cnt;
    lsb_idx = bit_cnt + CNT_W'(1);
    dout_d  = 1'b0;
    case (state)
      MSB:     dout_d = shift_reg[msb_idx];
      LSB:     dout_d = shift_reg[lsb_idx];
      default: dout_d = 1'b0;
    endcase
  end

  // DOUT changes only on falling SCLK so the master samples it stable.
  always_ff @(negedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      DOUT <= 1'b0;
    end else begin
      DOUT <= dout_d;
    end
  end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed bench for mcp3008_responder: table of command frames with
// hand-computed results, plus abort and mid-transfer reset sequences.
module tb_mcp3008_responder;

  logic             SCLK    = 1'b0;
  logic             reset_n = 1'b0;
  logic             CS_n    = 1'b1;
  logic             DIN     = 1'b0;
  logic [7:0][9:0]  chan_data;
  logic             DOUT;
  logic             DOUT_oe;
  logic             conv_done;
  logic             last_sgl;
  logic [2:0]       last_chan;
  logic [9:0]       last_result;

  int checks = 0;
  int errors = 0;

  logic [39:0] dout_bits;
  int          done_cnt;
  int          done_clk;
  int          oe_bad;

  typedef struct {
    logic       sgl;
    logic [2:0] ch;
    int         nclk;
    logic [9:0] res;
  } vec_t;

  vec_t vecs[9];

  always #5 SCLK = ~SCLK;

  mcp3008_responder dut (
    .SCLK        (SCLK),
    .reset_n     (reset_n),
    .CS_n        (CS_n),
    .DIN         (DIN),
    .chan_data   (chan_data),
    .DOUT        (DOUT),
    .DOUT_oe     (DOUT_oe),
    .conv_done   (conv_done),
    .last_sgl    (last_sgl),
    .last_chan   (last_chan),
    .last_result (last_result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Master bit for clock i of a frame 0x01, {SGL,D2,D1,D0,0000}, 0x00...
  function automatic logic cmd_bit(input int i, input logic sgl, input logic [2:0] ch);
    if (i == 8) return 1'b1;
    if (i == 9) return sgl;
    if (i >= 10 && i <= 12) return ch[12-i];
    return 1'b0;
  endfunction

  // DOUT seen at rising edge of clock i: B9..B0 on 15..24, B1..B9 on 25..33.
  function automatic logic [39:0] exp_stream(input logic [9:0] r, input int nclk);
    logic [39:0] e;
    e = '0;
    for (int i = 1; i <= nclk; i++) begin
      if (i >= 15 && i <= 24) e[i-1] = r[24-i];
      else if (i >= 25 && i <= 33) e[i-1] = r[i-24];
    end
    return e;
  endfunction

  // Drive nclk clocks with CS_n low; sample DOUT/conv_done after each rise.
  task automatic frame(input logic sgl, input logic [2:0] ch, input int nclk);
    dout_bits = '0;
    done_cnt  = 0;
    done_clk  = 0;
    oe_bad    = 0;
    for (int i = 1; i <= nclk; i++) begin
      @(negedge SCLK);
      CS_n = 1'b0;
      DIN  = cmd_bit(i, sgl, ch);
      @(posedge SCLK);
      #1;
      dout_bits[i-1] = DOUT;
      if (conv_done) begin
        done_cnt++;
        done_clk = i;
      end
      if (DOUT_oe !== 1'b1) oe_bad++;
    end
  endtask

  task automatic end_frame();
    @(negedge SCLK);
    CS_n = 1'b1;
    DIN  = 1'b0;
    repeat (2) @(posedge SCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chan_data[0] = 10'h155;
    chan_data[1] = 10'h3FF;
    chan_data[2] = 10'h2A5;
    chan_data[3] = 10'h000;
    chan_data[4] = 10'd300;
    chan_data[5] = 10'd100;
    chan_data[6] = 10'h0AB;
    chan_data[7] = 10'h301;

    vecs[0] = '{1'b1, 3'd2, 24, 10'h2A5};
    vecs[1] = '{1'b0, 3'd4, 24, 10'd200};
    vecs[2] = '{1'b0, 3'd5, 24, 10'h000};
    vecs[3] = '{1'b1, 3'd7, 40, 10'h301};
    vecs[4] = '{1'b1, 3'd0, 24, 10'h155};
    vecs[5] = '{1'b1, 3'd1, 24, 10'h3FF};
    vecs[6] = '{1'b0, 3'd1, 32, 10'h2AA};
    vecs[7] = '{1'b0, 3'd2, 24, 10'h2A5};
    vecs[8] = '{1'b0, 3'd7, 36, 10'h256};

    // Reset state.
    #12;
    chk("rst_dout", 64'(DOUT), 64'(1'b0));
    chk("rst_oe", 64'(DOUT_oe), 64'(1'b0));
    chk("rst_done", 64'(conv_done), 64'(1'b0));
    chk("rst_sgl", 64'(last_sgl), 64'(1'b0));
    chk("rst_chan", 64'(last_chan), 64'(3'd0));
    chk("rst_result", 64'(last_result), 64'(10'd0));
    @(negedge SCLK);
    reset_n = 1'b1;
    repeat (2) @(posedge SCLK);

    for (int k = 0; k < 9; k++) begin
      frame(vecs[k].sgl, vecs[k].ch, vecs[k].nclk);
      chk($sformatf("v%0d_stream", k), 64'(dout_bits), 64'(exp_stream(vecs[k].res, vecs[k].nclk)));
      chk($sformatf("v%0d_done_cnt", k), 64'(done_cnt), 64'(1));
      chk($sformatf("v%0d_done_clk", k), 64'(done_clk), 64'(13));
      chk($sformatf("v%0d_oe_low", k), 64'(oe_bad), 64'(0));
      chk($sformatf("v%0d_sgl", k), 64'(last_sgl), 64'(vecs[k].sgl));
      chk($sformatf("v%0d_chan", k), 64'(last_chan), 64'(vecs[k].ch));
      chk($sformatf("v%0d_result", k), 64'(last_result), 64'(vecs[k].res));
      end_frame();
      chk($sformatf("v%0d_oe_high", k), 64'(DOUT_oe), 64'(1'b0));
      chk($sformatf("v%0d_dout_idle", k), 64'(DOUT), 64'(1'b0));
    end

    // Deselect after clock 11: nothing latched, last_* keep vector 8.
    frame(1'b1, 3'd3, 11);
    end_frame();
    chk("abort11_done", 64'(done_cnt), 64'(0));
    chk("abort11_sgl", 64'(last_sgl), 64'(1'b0));
    chk("abort11_chan", 64'(last_chan), 64'(3'd7));
    chk("abort11_result", 64'(last_result), 64'(10'h256));

    frame(1'b1, 3'd6, 24);
    end_frame();
    chk("after_abort_stream", 64'(dout_bits), 64'(exp_stream(10'h0AB, 24)));
    chk("after_abort_done", 64'(done_cnt), 64'(1));
    chk("after_abort_chan", 64'(last_chan), 64'(3'd6));
    chk("after_abort_result", 64'(last_result), 64'(10'h0AB));

    // Deselect right after D0: SAMPLE edge sees CS_n high, no conversion.
    frame(1'b0, 3'd1, 12);
    end_frame();
    chk("abort12_done", 64'(done_cnt), 64'(0));
    chk("abort12_sgl", 64'(last_sgl), 64'(1'b1));
    chk("abort12_result", 64'(last_result), 64'(10'h0AB));

    // Reset mid-transfer at clock 16 (B8 of 0x301 is 1 on DOUT).
    frame(1'b1, 3'd7, 16);
    chk("pre_reset_dout", 64'(DOUT), 64'(1'b1));
    reset_n = 1'b0;
    #1;
    chk("mid_reset_dout", 64'(DOUT), 64'(1'b0));
    chk("mid_reset_done", 64'(conv_done), 64'(1'b0));
    chk("mid_reset_sgl", 64'(last_sgl), 64'(1'b0));
    chk("mid_reset_chan", 64'(last_chan), 64'(3'd0));
    chk("mid_reset_result", 64'(last_result), 64'(10'd0));
    chk("mid_reset_oe", 64'(DOUT_oe), 64'(1'b1));
    end_frame();
    @(negedge SCLK);
    reset_n = 1'b1;
    repeat (2) @(posedge SCLK);

    frame(1'b1, 3'd2, 24);
    end_frame();
    chk("post_reset_stream", 64'(dout_bits), 64'(exp_stream(10'h2A5, 24)));
    chk("post_reset_done_clk", 64'(done_clk), 64'(13));
    chk("post_reset_sgl", 64'(last_sgl), 64'(1'b1));
    chk("post_reset_chan", 64'(last_chan), 64'(3'd2));
    chk("post_reset_result", 64'(last_result), 64'(10'h2A5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcp3008_responder.md
Name: mcp3008_responder

Overview:
- SPI responder that emulates an MCP3008 8-channel 10-bit ADC: decodes the command stream on DIN and returns the conversion result on DOUT.
- Result values come from a parallel input bus, not a real ADC.
- Used as a synthesizable stand-in for the external chip: loopback on FPGA with the ADC-polling master, and as the device model in its benches.
- Supports single-ended and pseudo-differential modes, MSB-first data and the LSB-first trailer.

Parameters:
N, 10, result width in bits
CHANNELS, 8, number of input channels (fixed at 8; the command carries 3 channel bits)

Ports:
SCLK  input  1  SPI clock driven by the master; the only clock
reset_n  input  1  reset: asynchronous, active-low
CS_n  input  1  chip select, active-low
DIN  input  1  command data from the master
chan_data  input  [CHANNELS-1:0][N-1:0]  value presented per channel
DOUT  output  1  result data to the master
DOUT_oe  output  1  DOUT drive enable; top level tri-states DOUT when 0
conv_done  output  1  one-SCLK pulse when a sample is latched
last_sgl  output  1  SGL/DIFF bit of the last accepted command
last_chan  output  3  D2..D0 of the last accepted command
last_result  output  N  value latched by the last conversion

Behaviour:
- Reset values: state IDLE, DOUT=0, conv_done=0, last_sgl=0, last_chan=0, last_result=0, shift register=0, counters=0.
- DOUT_oe = ~CS_n, combinational. It is 0 during reset only if CS_n is high.
- DIN and CS_n are sampled on rising SCLK. DOUT is updated only on falling SCLK.
- Any rising edge with CS_n=1 forces IDLE and clears the bit counter. This aborts any transaction mid-stream, with no outputs updated except DOUT<=0 on the next falling edge.
- States:
  - IDLE: on rising edge with CS_n=0, go to WAIT_START. That same edge is also evaluated as a WAIT_START bit.
  - WAIT_START: DIN=0 stays here (leading zeros ignored). DIN=1 goes to CMD with cnt=0.
  - CMD: captures 4 bits MSB-first: SGL, D2, D1, D0. The edge capturing D0 (call it edge k) goes to SAMPLE.
  - SAMPLE (edge k+1): latch the result into the shift register and last_result; update last_sgl/last_chan; conv_done=1 for this cycle only. Go to NULL.
  - NULL: DOUT=0 on falling edge k+1 (null bit). Go to MSB.
  - MSB: falling edges k+2..k+11 drive B9..B0. After 10 bits go to LSB.
  - LSB: falling edges k+12..k+20 drive B1..B9. Go to ZERO.
  - ZERO: DOUT=0 until CS_n rises.
- DOUT=0 on every falling edge in IDLE, WAIT_START, CMD, SAMPLE and ZERO.
- Result computation, using chan_data at edge k+1:
  - SGL=1: result = chan_data[chan].
  - SGL=0: pair p = chan[2:1]. chan[0]=0 gives IN+=2p, IN-=2p+1; chan[0]=1 gives the swapped pair. result = IN+ - IN- if IN+ >= IN-, else 0 (saturating, N-bit, no wrap).
- With the standard 24-clock frame (0x01, {SGL,D2..D0,4'b0}, 0x00):
  - start bit on clock 8, D0 on clock 12, null bit on clock 14
  - B9..B0 on clocks 15..24, read by the master at falling edges 14..23 from its own count
- CS_n held low beyond 24 clocks yields the LSB trailer, then zeros.
- A CS_n low pulse with too few clocks gives no conv_done and leaves last_* unchanged.

Decomposition:
- Package mcp3008_pkg: N, CHANNELS, CMD_BITS=4, frame-length constant 24, state_t enum (IDLE, WAIT_START, CMD, SAMPLE, NULL, MSB, LSB, ZERO).
- Shared with the polling master.
- One sub-module, mcp3008_result_sel: combinational channel mux plus saturating differential subtract. Inputs chan_data, sgl, chan; output [N-1:0] result.

Test Plan:
- chan_data[2]=10'h2A5; send 24-bit frame 0x01,0xA0,0x00 -> DOUT bits 15..24 = 10'b1010100101, bit 14 = 0, conv_done pulses once at clock 13, last_chan=2, last_sgl=1.
- Diff: chan_data[4]=300, chan_data[5]=100, cmd SGL=0, chan=3'b100 -> result 200. Then chan=3'b101 -> result 0 (saturation).
- 40-clock frame on channel 7 with value 10'h301 -> B9..B0 = 1100000001, then B1..B9 = 000000011, then zeros to the end; DOUT_oe=1 throughout CS_n low.
- CS_n raised after clock 11 of a frame -> no conv_done, last_* unchanged. Next full frame decodes correctly.
- reset_n asserted at clock 16 mid-transfer -> all outputs 0 immediately. After release, the next frame decodes correctly.
- Loopback with the polling master: chan_data[0]=10'h155, chan_data[1]=10'h3FF -> master's adc outputs settle to 10'h155 and 10'h3FF.
